// File: rtl/pcode_addr_gen_if.sv
// Handshake/bus bundle for the pcode address NCO.
// PCODE_EPOCH_CNT_EN adds the epoch_cnt output.
interface pcode_addr_gen_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ACC_W  = 32
);
  logic              en;
  logic [ACC_W-1:0]  fcw;
  logic              fcw_we;
  logic              phase_load;
  logic [ADDR_W-1:0] phase_val;
  logic              slew_req;
  logic [7:0]        slew_chips;
  logic              slew_busy;
  logic [ADDR_W-1:0] pcode_addr;
  logic              chip_stb;
  logic              epoch;
`ifdef PCODE_EPOCH_CNT_EN
  logic [15:0]       epoch_cnt;

  modport master (
    output en, fcw, fcw_we, phase_load, phase_val, slew_req, slew_chips,
    input  slew_busy, pcode_addr, chip_stb, epoch, epoch_cnt
  );
  modport slave (
    input  en, fcw, fcw_we, phase_load, phase_val, slew_req, slew_chips,
    output slew_busy, pcode_addr, chip_stb, epoch, epoch_cnt
  );
`else
  modport master (
    output en, fcw, fcw_we, phase_load, phase_val, slew_req, slew_chips,
    input  slew_busy, pcode_addr, chip_stb, epoch
  );
  modport slave (
    input  en, fcw, fcw_we, phase_load, phase_val, slew_req, slew_chips,
    output slew_busy, pcode_addr, chip_stb, epoch
  );
`endif
endinterface

// File: rtl/pcode_addr_gen.sv
// Code-phase NCO producing the pcode ROM chip address, with phase load and chip slew.
// Optional feature macro: PCODE_EPOCH_CNT_EN (adds epoch_cnt).
module pcode_addr_gen #(
  parameter int unsigned CODE_LEN = 20460,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  pcode_addr_gen_if.slave  bus
);
  typedef enum logic {IDLE, SLEW} state_e;

  localparam int unsigned SUM_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] CODE_LEN_S = SUM_W'(CODE_LEN);

  state_e            state_q;
  logic [ACC_W-1:0]  rate_q, acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d, load_addr;
  logic [7:0]        cnt_q;
  logic              busy_q, chip_stb_q, epoch_q;
  logic              carry, wrap;
  logic [1:0]        step;
  logic [SUM_W-1:0]  addr_sum, addr_wrapped;
`ifdef PCODE_EPOCH_CNT_EN
  logic [15:0]       epoch_cnt_q;
`endif

  // Phase accumulator, address step and wrap detection
  always_comb begin
    {carry, acc_d} = {1'b0, acc_q} + {1'b0, rate_q};
    if (!bus.en) begin
      carry = 1'b0;
      acc_d = acc_q;
    end
    step         = 2'(carry) + ((state_q == SLEW) ? 2'd1 : 2'd0);
    addr_sum     = {1'b0, addr_q} + SUM_W'(step);
    wrap         = (addr_sum >= CODE_LEN_S);
    addr_wrapped = addr_sum - CODE_LEN_S;
    addr_d       = wrap ? addr_wrapped[ADDR_W-1:0] : addr_sum[ADDR_W-1:0];
    load_addr    = ({1'b0, bus.phase_val} >= CODE_LEN_S) ? '0 : bus.phase_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rate_q      <= '0;
      acc_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      chip_stb_q  <= 1'b0;
      epoch_q     <= 1'b0;
`ifdef PCODE_EPOCH_CNT_EN
      epoch_cnt_q <= '0;
`endif
    end else begin
      if (bus.fcw_we) rate_q <= bus.fcw;
      if (bus.phase_load) begin
        // Absolute load overrides NCO advance and aborts any slew
        addr_q      <= load_addr;
        acc_q       <= '0;
        chip_stb_q  <= 1'b1;
        epoch_q     <= (load_addr == '0);
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        cnt_q       <= '0;
`ifdef PCODE_EPOCH_CNT_EN
        epoch_cnt_q <= '0;
`endif
      end else begin
        acc_q      <= acc_d;
        addr_q     <= addr_d;
        chip_stb_q <= (step != 2'd0);
        epoch_q    <= wrap;
`ifdef PCODE_EPOCH_CNT_EN
        if (wrap) epoch_cnt_q <= epoch_cnt_q + 16'd1;
`endif
        case (state_q)
          IDLE: begin
            if (bus.slew_req && (bus.slew_chips != 8'd0)) begin
              state_q <= SLEW;
              cnt_q   <= bus.slew_chips;
              busy_q  <= 1'b1;
            end
          end
          SLEW: begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pcode_addr = addr_q;
  assign bus.chip_stb   = chip_stb_q;
  assign bus.epoch      = epoch_q;
  assign bus.slew_busy  = busy_q;
`ifdef PCODE_EPOCH_CNT_EN
  assign bus.epoch_cnt  = epoch_cnt_q;
`endif
endmodule

// File: tb/tb_pcode_addr_gen.sv
// Self-checking bench for pcode_addr_gen: behavioural model compared every cycle plus directed literals.
module tb_pcode_addr_gen;
  localparam int unsigned CODE_LEN = 20460;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned ACC_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  pcode_addr_gen_if #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

  pcode_addr_gen #(.CODE_LEN(CODE_LEN), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer chip position, remaining slew chips
  logic [31:0] m_rate = '0, m_acc = '0;
  logic [32:0] m_sum;
  int m_addr = 0, m_left = 0, m_ecnt = 0, m_step = 0, m_next = 0;
  bit m_stb = 0, m_epoch = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rate = '0; m_acc = '0; m_addr = 0; m_left = 0; m_ecnt = 0;
      m_stb = 0; m_epoch = 0;
    end else begin
      if (bus.phase_load) begin
        m_addr  = (int'(bus.phase_val) >= CODE_LEN) ? 0 : int'(bus.phase_val);
        m_acc   = '0;
        m_stb   = 1;
        m_epoch = (m_addr == 0);
        m_left  = 0;
        m_ecnt  = 0;
      end else begin
        m_step = 0;
        if (bus.en) begin
          m_sum  = {1'b0, m_acc} + {1'b0, m_rate};
          m_acc  = m_sum[31:0];
          m_step = int'(m_sum[32]);
        end
        if (m_left > 0) begin
          m_step += 1;
          m_left -= 1;
        end else if (bus.slew_req && bus.slew_chips != 0) begin
          m_left = int'(bus.slew_chips);
        end
        m_next  = m_addr + m_step;
        m_epoch = (m_next >= CODE_LEN);
        m_addr  = m_next % CODE_LEN;
        m_stb   = (m_step != 0);
        if (m_epoch) m_ecnt = (m_ecnt + 1) % 65536;
      end
      if (bus.fcw_we) m_rate = bus.fcw;
    end
  end

  always @(negedge clk) begin
    chk("addr", bus.pcode_addr, m_addr);
    chk("chip_stb", bus.chip_stb, m_stb);
    chk("epoch", bus.epoch, m_epoch);
    chk("slew_busy", bus.slew_busy, m_left > 0);
`ifdef PCODE_EPOCH_CNT_EN
    chk("epoch_cnt", bus.epoch_cnt, m_ecnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int val);
    bus.phase_load = 1; bus.phase_val = 16'(val);
    tick();
    bus.phase_load = 0;
  endtask

  int n, busy_cycles, ep_cnt;
  int got_addr[3];
  int got_ep[3];

  initial begin
    bus.en = 0; bus.fcw = '0; bus.fcw_we = 0; bus.phase_load = 0; bus.phase_val = '0;
    bus.slew_req = 0; bus.slew_chips = '0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", bus.pcode_addr, 0);
    chk("rst_busy", bus.slew_busy, 0);
    chk("rst_stb", bus.chip_stb, 0);
    chk("rst_epoch", bus.epoch, 0);
    rst = 0;
    tick();

    // Half-rate NCO: first epoch 2*CODE_LEN edges after the first add
    bus.fcw = 32'h8000_0000; bus.fcw_we = 1; bus.en = 1;
    tick();
    bus.fcw_we = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 2) chk("first_chip", bus.pcode_addr, 1);
    end while (!bus.epoch && n < 50000);
    chk("first_epoch_cycle", n, 2 * CODE_LEN);
    chk("wrap_addr", bus.pcode_addr, 0);
    tick();
    chk("epoch_single", bus.epoch, 0);

    // Full-rate with simultaneous fcw_we and phase_load near the end of the code
    bus.fcw = 32'hFFFF_FFFF; bus.fcw_we = 1;
    load(20458);
    bus.fcw_we = 0;
    chk("load_addr", bus.pcode_addr, 20458);
    chk("load_stb", bus.chip_stb, 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin tick(); n++; end while (!bus.chip_stb && n < 10);
      got_addr[k] = int'(bus.pcode_addr);
      got_ep[k]   = int'(bus.epoch);
    end
    chk("seq_a0", got_addr[0], 20459); chk("seq_e0", got_ep[0], 0);
    chk("seq_a1", got_addr[1], 0);     chk("seq_e1", got_ep[1], 1);
    chk("seq_a2", got_addr[2], 1);     chk("seq_e2", got_ep[2], 0);
    load(30000);
    chk("oob_addr", bus.pcode_addr, 0);
    chk("oob_epoch", bus.epoch, 1);

    // Slew with NCO stopped, extra request while busy is dropped
    bus.en = 0;
    load(100);
    bus.slew_req = 1; bus.slew_chips = 5;
    tick();
    bus.slew_req = 0;
    chk("slew_start_addr", bus.pcode_addr, 100);
    busy_cycles = int'(bus.slew_busy);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) chk("slew_first", bus.pcode_addr, 101);
      busy_cycles += int'(bus.slew_busy);
      if (i == 1) begin bus.slew_req = 1; bus.slew_chips = 7; end
      if (i == 2) bus.slew_req = 0;
    end
    chk("slew_busy_cycles", busy_cycles, 5);
    chk("slew_final", bus.pcode_addr, 105);

    // Slew combined with NCO carry: step of 2 across the wrap
    bus.en = 1; bus.fcw = 32'h8000_0000; bus.fcw_we = 1;
    load(20459);
    bus.fcw_we = 0;
    bus.slew_req = 1; bus.slew_chips = 3;
    tick();
    bus.slew_req = 0;
    ep_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) chk("step2_wrap_addr", bus.pcode_addr, 1);
      ep_cnt += int'(bus.epoch);
    end
    chk("slew_epoch_count", ep_cnt, 1);

    // phase_load on the 2nd slew cycle aborts it; load beats simultaneous slew_req
    bus.en = 0;
    load(500);
    bus.slew_req = 1; bus.slew_chips = 10;
    tick();
    bus.slew_req = 0;
    tick();
    chk("abort_pre", bus.pcode_addr, 501);
    load(7);
    chk("abort_busy", bus.slew_busy, 0);
    chk("abort_addr", bus.pcode_addr, 7);
    repeat (3) tick();
    chk("abort_hold", bus.pcode_addr, 7);
    bus.slew_req = 1; bus.slew_chips = 4;
    load(42);
    bus.slew_req = 0;
    tick();
    chk("load_wins_busy", bus.slew_busy, 0);
    chk("load_wins_addr", bus.pcode_addr, 42);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.en         = ($urandom_range(0, 3) != 0);
      bus.fcw_we     = ($urandom_range(0, 31) == 0);
      bus.fcw        = ($urandom_range(0, 1) != 0) ? $urandom : {2'b11, 30'($urandom)};
      bus.phase_load = ($urandom_range(0, 63) == 0);
      bus.phase_val  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(20440, 20459));
      bus.slew_req   = ($urandom_range(0, 15) == 0);
      bus.slew_chips = 8'($urandom_range(0, 20));
      tick();
    end
    bus.fcw_we = 0; bus.phase_load = 0; bus.slew_req = 0;

    // Asynchronous reset between edges mid-slew
    bus.en = 0;
    load(300);
    bus.slew_req = 1; bus.slew_chips = 20;
    tick();
    bus.slew_req = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("arst_addr", bus.pcode_addr, 0);
    chk("arst_busy", bus.slew_busy, 0);
    chk("arst_stb", bus.chip_stb, 0);
    chk("arst_epoch", bus.epoch, 0);
    tick();
    rst = 0;
    tick();

`ifdef PCODE_EPOCH_CNT_EN
    bus.en = 1; bus.fcw = 32'hFFFF_FFFF; bus.fcw_we = 1;
    load(20459);
    bus.fcw_we = 0;
    chk("ecnt_after_load", bus.epoch_cnt, 0);
    n = 0;
    do begin tick(); n++; end while (!bus.epoch && n < 10);
    chk("ecnt_one", bus.epoch_cnt, 1);
    load(5);
    chk("ecnt_cleared", bus.epoch_cnt, 0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
